// File: rtl/fluxo_dados_genius_param.sv
// fluxo_dados_genius_param: parametrised sequence-memory game datapath (counters, play register, RAM, timer).
// Optional FLUXO_LFSR_EN: RAM write data comes from an 8-bit LFSR as a one-hot word instead of J.
module fluxo_dados_genius_param #(
  parameter int N_CHAVES = 4,
  parameter int DEPTH    = 16,
  parameter int LIMITE_0 = 15,
  parameter int LIMITE_1 = 3,
  parameter int TIMEOUT  = 5000,
  localparam int AW      = $clog2(DEPTH),
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zeraE,
  input  logic                contaE,
  input  logic                zeraL,
  input  logic                contaL,
  input  logic                zeraR,
  input  logic                registraR,
  input  logic                zeraT,
  input  logic                contaT,
  input  logic                escreveM,
  input  logic                modo,
  input  logic [N_CHAVES-1:0] chaves,
  output logic                fimE,
  output logic                fimL,
  output logic                enderecoIgualRodada,
  output logic                igual,
  output logic                jogada_feita,
  output logic                jogada_invalida,
  output logic                fimT,
  output logic                meioT,
  output logic                db_tem_jogada,
  output logic [AW-1:0]       db_contagem,
  output logic [AW-1:0]       db_rodada,
  output logic [N_CHAVES-1:0] db_memoria,
  output logic [N_CHAVES-1:0] db_jogada
);
  localparam logic [AW-1:0] E_MAX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LIM0  = AW'(LIMITE_0);
  localparam logic [AW-1:0] LIM1  = AW'(LIMITE_1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MID = TW'(TIMEOUT / 2);
  logic [AW-1:0]       e, l;
  logic [TW-1:0]       t;
  logic [N_CHAVES-1:0] j, rd, wdata;
  logic                inv, prev, armed, tem;
  logic [N_CHAVES-1:0] mem [DEPTH];
  assign tem = |chaves;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e     <= '0;
      l     <= '0;
      t     <= '0;
      j     <= '0;
      inv   <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      e     <= zeraE ? '0 : contaE ? (e == E_MAX ? '0 : e + AW'(1)) : e;
      l     <= zeraL ? '0 : contaL ? (l == E_MAX ? '0 : l + AW'(1)) : l;
      t     <= (zeraT || jogada_feita) ? '0 : (contaT && t < T_MAX) ? t + TW'(1) : t;
      j     <= zeraR ? '0 : registraR ? chaves : j;
      inv   <= zeraR ? 1'b0 : registraR ? !$onehot(chaves) : inv;
      prev  <= zeraE ? 1'b0 : tem;
      // keys held through reset release must be let go once before a play can register
      armed <= armed | ~tem;
    end
  end
`ifdef FLUXO_LFSR_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= 8'h01;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign wdata = {{(N_CHAVES-1){1'b0}}, 1'b1} << (lfsr % N_CHAVES);
`else
  assign wdata = j;
`endif
  // read-before-write: a same-address write returns the previous word
  always_ff @(posedge clock) begin
    if (escreveM) mem[e] <= wdata;
    rd <= mem[e];
  end
  assign jogada_feita        = tem & ~prev & armed;
  assign fimE                = e == E_MAX;
  assign fimL                = l == (modo ? LIM1 : LIM0);
  assign enderecoIgualRodada = e == l;
  assign jogada_invalida     = inv;
  assign igual               = (rd == j) && !inv;
  assign fimT                = t == T_MAX;
  assign meioT               = t >= T_MID;
  assign db_tem_jogada       = tem;
  assign db_contagem         = e;
  assign db_rodada           = l;
  assign db_memoria          = rd;
  assign db_jogada           = j;
endmodule

// File: tb/tb_fluxo_dados_genius_param.sv
// tb_fluxo_dados_genius_param: directed self-checking bench for the game datapath (TIMEOUT=8).
module tb_fluxo_dados_genius_param;
  logic clock = 1'b0, reset = 1'b0;
  logic zeraE = 0, contaE = 0, zeraL = 0, contaL = 0, zeraR = 0, registraR = 0;
  logic zeraT = 0, contaT = 0, escreveM = 0, modo = 0;
  logic [3:0] chaves = '0;
  logic fimE, fimL, enderecoIgualRodada, igual, jogada_feita, jogada_invalida, fimT, meioT, db_tem_jogada;
  logic [3:0] db_contagem, db_rodada, db_memoria, db_jogada;
  int passed = 0, total = 0;
  always #5 clock = ~clock;
  fluxo_dados_genius_param #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT), .escreveM(escreveM),
    .modo(modo), .chaves(chaves), .fimE(fimE), .fimL(fimL), .enderecoIgualRodada(enderecoIgualRodada),
    .igual(igual), .jogada_feita(jogada_feita), .jogada_invalida(jogada_invalida), .fimT(fimT),
    .meioT(meioT), .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem), .db_rodada(db_rodada),
    .db_memoria(db_memoria), .db_jogada(db_jogada)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    tick(2);
    chk("rst_E", db_contagem, 0);
    chk("rst_L", db_rodada, 0);
    chk("rst_J", db_jogada, 0);
    chk("rst_pulse", jogada_feita, 0);
    chk("rst_eqEL", enderecoIgualRodada, 1);
    chk("rst_fimL", fimL, 0);
    chk("rst_fimT", fimT, 0);
    chk("rst_meioT", meioT, 0);
    chk("rst_inv", jogada_invalida, 0);
    reset = 1;
    tick();
    contaE = 1; tick(3); contaE = 0;
    chk("E_is3", db_contagem, 3);
    chaves = 4'b0010; registraR = 1; tick(); registraR = 0; chaves = 0;
    chk("J_0010", db_jogada, 4'b0010);
    escreveM = 1; tick(); escreveM = 0; tick();
    chk("rd_0010", db_memoria, 4'b0010);
    chk("igual_hit", igual, 1);
    zeraE = 1; tick(); zeraE = 0;
    chk("zeraE", db_contagem, 0);
    contaE = 1; tick(3); contaE = 0; tick();
    chk("reread_0010", db_memoria, 4'b0010);
    chk("reigual", igual, 1);
    chaves = 4'b0100; registraR = 1; tick(); registraR = 0; chaves = 0;
    chk("igual_miss", igual, 0);
    escreveM = 1; tick(); escreveM = 0;
    chk("rdw_old", db_memoria, 4'b0010);
    tick();
    chk("rdw_new", db_memoria, 4'b0100);
    chk("igual_0100", igual, 1);
    chaves = 4'b0110; registraR = 1; tick(); registraR = 0; chaves = 0;
    chk("inv_0110", jogada_invalida, 1);
    escreveM = 1; tick(); escreveM = 0; tick();
    chk("rd_0110", db_memoria, 4'b0110);
    chk("igual_inv", igual, 0);
    registraR = 1; tick(); registraR = 0;
    chk("inv_0000", jogada_invalida, 1);
    chk("igual_inv0", igual, 0);
    zeraR = 1; registraR = 1; chaves = 4'b0001; tick(); zeraR = 0; registraR = 0; chaves = 0;
    chk("zeraR_J", db_jogada, 0);
    chk("zeraR_inv", jogada_invalida, 0);
    zeraE = 1; zeraL = 1; tick(); zeraE = 0; zeraL = 0;
    modo = 1; contaL = 1; tick(3); contaL = 0;
    chk("L3", db_rodada, 3);
    chk("fimL_m1", fimL, 1);
    modo = 0; #1;
    chk("fimL_m0", fimL, 0);
    contaL = 1; tick(12); contaL = 0;
    chk("L15_fimL", fimL, 1);
    contaE = 1; tick(14);
    chk("fimE_14", fimE, 0);
    tick();
    chk("fimE_15", fimE, 1);
    chk("eqEL_15", enderecoIgualRodada, 1);
    contaL = 1; tick(); contaL = 0; contaE = 0;
    chk("L_wrap", db_rodada, 0);
    chk("E_wrap", db_contagem, 0);
    contaE = 1; tick(); zeraE = 1; tick(); zeraE = 0; contaE = 0;
    chk("zera_conta", db_contagem, 0);
    zeraT = 1; tick(); zeraT = 0;
    contaT = 1; tick(3);
    chk("meioT_3", meioT, 0);
    tick();
    chk("meioT_4", meioT, 1);
    chk("fimT_4", fimT, 0);
    tick(3);
    chk("fimT_7", fimT, 1);
    tick(2);
    chk("fimT_sat", fimT, 1);
    chaves = 4'b0001; #1;
    chk("pulse_hi", jogada_feita, 1);
    tick();
    chk("pulse_lo", jogada_feita, 0);
    chk("T_clr_fim", fimT, 0);
    chk("T_clr_meio", meioT, 0);
    contaT = 0;
    reset = 0; tick(2); reset = 1; tick();
    chk("held_nopulse", jogada_feita, 0);
    chaves = 0; tick(); chaves = 4'b1000; #1;
    chk("repress", jogada_feita, 1);
    tick(); chaves = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
